// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: shared FSM state type and synchroniser depth for the req/ack CDC link
package cdc_hs_pkg;
  typedef enum logic [1:0] {HS_IDLE, HS_REQ, HS_REL} hs_state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/double_flipflop.sv
// double_flipflop: SYNC_STAGES-deep synchroniser for one asynchronous bit
// Ports: clk, reset_n (async, active-low, clears to 0), d (async input), q (synchronised output)
module double_flipflop
  import cdc_hs_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sr <= '0;
    else sr <= {sr[SYNC_STAGES-2:0], d};
  assign q = sr[SYNC_STAGES-1];
endmodule

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source-domain half of a 4-phase req/ack CDC link
// Ports: clk, reset_n (async, active-low); send_valid/send_data/send_ready accept a word;
//   req/xfer_data drive the destination; ack_async returns from it (unsynchronised);
//   done pulses once per completed handshake; timeout_err is a sticky abort flag.
// Optional feature: define CDC_TIMEOUT_EN to abort a REQ phase after TIMEOUT_CYCLES.
module cdc_handshake_tx
  import cdc_hs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              send_valid,
  input  logic [DATA_W-1:0] send_data,
  output logic              send_ready,
  output logic              req,
  output logic [DATA_W-1:0] xfer_data,
  input  logic              ack_async,
  output logic              done,
  output logic              timeout_err
);
  hs_state_t state_q, state_d;
  logic ack_s, req_d, done_d, to_hit;
  logic [DATA_W-1:0] data_d;
  double_flipflop u_sync (.clk(clk), .reset_n(reset_n), .d(ack_async), .q(ack_s));
  assign send_ready = state_q == HS_IDLE && !ack_s;
`ifdef CDC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  // cnt_q holds the number of REQ cycles already elapsed, so this is the last allowed one
  assign to_hit = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else if (state_q != HS_REQ) cnt_q <= '0;
    else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) cnt_q <= cnt_q + 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) timeout_err <= 1'b0;
    else if (state_q == HS_REQ && !ack_s && to_hit) timeout_err <= 1'b1;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    req_d = req;
    data_d = xfer_data;
    done_d = 1'b0;
    case (state_q)
      HS_IDLE: if (send_valid && send_ready) begin
        state_d = HS_REQ;
        req_d = 1'b1;
        data_d = send_data;
      end
      HS_REQ: if (ack_s || to_hit) begin
        state_d = HS_REL;
        req_d = 1'b0;
      end
      HS_REL: if (!ack_s) begin
        state_d = HS_IDLE;
        done_d = 1'b1;
      end
      default: begin
        state_d = HS_IDLE;
        req_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= HS_IDLE;
      req <= 1'b0;
      xfer_data <= '0;
      done <= 1'b0;
    end else begin
      state_q <= state_d;
      req <= req_d;
      xfer_data <= data_d;
      done <= done_d;
    end
endmodule
